// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, debug and memory-side signals around the data memory arbiter.
// slave = arbiter view, master = surrounding system (requesters plus memory).
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                core_req;
    logic                core_we;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic [DATA_W/8-1:0] core_mask;
    logic                core_gnt;
    logic                core_stall;
    logic                core_rvalid;
    logic [DATA_W-1:0]   core_rdata;

    logic                dbg_req;
    logic                dbg_we;
    logic [ADDR_W-1:0]   dbg_addr;
    logic [DATA_W-1:0]   dbg_wdata;
    logic [DATA_W/8-1:0] dbg_mask;
    logic                dbg_gnt;
    logic                dbg_rvalid;
    logic [DATA_W-1:0]   dbg_rdata;

    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_mask;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_mask,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mask,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_mask,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_mask,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mask,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_mask,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Per-cycle arbiter sharing a single-port, 1-cycle-latency data memory between the core
// (fixed priority) and a debug/loader port that is guaranteed service after MAX_WAIT refusals.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]  wait_cnt;
    logic              rd_pend;
    logic              rd_owner_dbg;
    logic [DATA_W-1:0] core_hold;
    logic [DATA_W-1:0] dbg_hold;
    logic              core_gnt;
    logic              dbg_gnt;
    logic              dbg_pri;

    // No grant is ever issued while held in reset, even with requests pending.
    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        dbg_pri  = (wait_cnt == WAIT_MAX);
        if (rst) begin
            if (dbg_pri && bus.dbg_req) begin
                dbg_gnt = 1'b1;
            end else if (bus.core_req) begin
                core_gnt = 1'b1;
            end else if (bus.dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        bus.mem_en    = core_gnt | dbg_gnt;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_mask  = '0;
        if (core_gnt) begin
            bus.mem_we    = bus.core_we;
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
            bus.mem_mask  = bus.core_mask;
        end else if (dbg_gnt) begin
            bus.mem_we    = bus.dbg_we;
            bus.mem_addr  = bus.dbg_addr;
            bus.mem_wdata = bus.dbg_wdata;
            bus.mem_mask  = bus.dbg_mask;
        end
    end

    assign bus.core_gnt   = core_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.core_stall = bus.core_req & ~core_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (dbg_gnt) begin
            wait_cnt <= '0;
        end else if (bus.dbg_req) begin
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // A read granted in the same cycle as a returning read keeps rd_pend set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend      <= 1'b0;
            rd_owner_dbg <= 1'b0;
        end else begin
            rd_pend <= bus.mem_en & ~bus.mem_we;
            if (bus.mem_en && !bus.mem_we) begin
                rd_owner_dbg <= dbg_gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_hold <= '0;
            dbg_hold  <= '0;
        end else if (rd_pend) begin
            if (rd_owner_dbg) begin
                dbg_hold <= bus.mem_rdata;
            end else begin
                core_hold <= bus.mem_rdata;
            end
        end
    end

    // Return data passes straight through in the valid cycle; otherwise the last value is held.
    assign bus.core_rvalid = rd_pend & ~rd_owner_dbg;
    assign bus.dbg_rvalid  = rd_pend & rd_owner_dbg;
    assign bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : core_hold;
    assign bus.dbg_rdata   = bus.dbg_rvalid ? bus.mem_rdata : dbg_hold;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural model with a per-cycle compare process,
// a simple synchronous memory, and literal checks of the main scenarios.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 32'h5A00_0000 | 32'(i);
            ref_mem[i] = 32'h5A00_0000 | 32'(i);
        end
        env_mem[16] = 32'hDEAD_BEEF; ref_mem[16] = 32'hDEAD_BEEF;
        env_mem[32] = 32'hAAAA_AAAA; ref_mem[32] = 32'hAAAA_AAAA;
    end

    // Memory seen by the DUT: synchronous, read data one cycle after the strobe.
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we)
                env_mem[bus.mem_addr[9:2]] <= merge(env_mem[bus.mem_addr[9:2]], bus.mem_wdata, bus.mem_mask);
            else
                bus.mem_rdata <= env_mem[bus.mem_addr[9:2]];
        end
    end

    // Model state: refusal count, one outstanding read (owner + data), last returned data per port.
    int          m_wait;
    bit          m_pend, m_pend_dbg;
    logic [31:0] m_pend_data, m_core_hold, m_dbg_hold;

    function automatic void decide(output bit gc, output bit gd);
        gc = 0;
        gd = 0;
        if (rst) begin
            if (m_wait == MAX_WAIT && bus.dbg_req) gd = 1;
            else if (bus.core_req) gc = 1;
            else if (bus.dbg_req) gd = 1;
        end
    endfunction

    always @(posedge clk or negedge rst) begin : model_upd
        bit gc, gd;
        logic we;
        logic [31:0] addr, wd;
        logic [3:0] mk;
        if (!rst) begin
            m_wait = 0; m_pend = 0; m_pend_dbg = 0;
            m_pend_data = 0; m_core_hold = 0; m_dbg_hold = 0;
        end else begin
            if (m_pend) begin
                if (m_pend_dbg) m_dbg_hold = m_pend_data;
                else m_core_hold = m_pend_data;
            end
            decide(gc, gd);
            m_pend = 0;
            if (gc || gd) begin
                we   = gc ? bus.core_we    : bus.dbg_we;
                addr = gc ? bus.core_addr  : bus.dbg_addr;
                wd   = gc ? bus.core_wdata : bus.dbg_wdata;
                mk   = gc ? bus.core_mask  : bus.dbg_mask;
                if (we) begin
                    ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], wd, mk);
                end else begin
                    m_pend = 1;
                    m_pend_dbg = gd;
                    m_pend_data = ref_mem[addr[9:2]];
                end
            end
            if (gd) m_wait = 0;
            else if (bus.dbg_req) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else m_wait = 0;
        end
    end

    always @(negedge clk) begin : cmp
        bit gc, gd;
        logic [31:0] ea, ewd;
        logic [3:0] em;
        logic ewe, ecv, edv;
        decide(gc, gd);
        ewe = 0; ea = 0; ewd = 0; em = 0;
        if (gc) begin ewe = bus.core_we; ea = bus.core_addr; ewd = bus.core_wdata; em = bus.core_mask; end
        else if (gd) begin ewe = bus.dbg_we; ea = bus.dbg_addr; ewd = bus.dbg_wdata; em = bus.dbg_mask; end
        ecv = m_pend && !m_pend_dbg;
        edv = m_pend && m_pend_dbg;
        chk("m_core_gnt", bus.core_gnt, gc);
        chk("m_dbg_gnt", bus.dbg_gnt, gd);
        chk("m_core_stall", bus.core_stall, bus.core_req & !gc);
        chk("m_mem_en", bus.mem_en, gc | gd);
        chk("m_mem_we", bus.mem_we, ewe);
        chk("m_mem_addr", bus.mem_addr, ea);
        chk("m_mem_wdata", bus.mem_wdata, ewd);
        chk("m_mem_mask", bus.mem_mask, em);
        chk("m_core_rvalid", bus.core_rvalid, ecv);
        chk("m_dbg_rvalid", bus.dbg_rvalid, edv);
        chk("m_core_rdata", bus.core_rdata, ecv ? m_pend_data : m_core_hold);
        chk("m_dbg_rdata", bus.dbg_rdata, edv ? m_pend_data : m_dbg_hold);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic core_set(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        bus.core_req = r; bus.core_we = w; bus.core_addr = a; bus.core_wdata = d; bus.core_mask = m;
    endtask

    task automatic dbg_set(input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
        bus.dbg_req = r; bus.dbg_we = w; bus.dbg_addr = a; bus.dbg_wdata = d; bus.dbg_mask = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] pat, stl;
        logic [4:0] pat5;
        core_set(0, 0, 0, 0, 0);
        dbg_set(0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        step();

        // Requests during reset: nothing granted, stall visible.
        core_set(1, 0, 32'h10, 0, 4'hF);
        smp();
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_core_gnt", bus.core_gnt, 0);
        chk("rst_core_stall", bus.core_stall, 1);
        chk("rst_core_rvalid", bus.core_rvalid, 0);
        chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
        chk("rst_core_rdata", bus.core_rdata, 0);
        rst = 1'b1;
        #1;
        chk("rel_core_gnt", bus.core_gnt, 1);
        chk("rel_core_stall", bus.core_stall, 0);
        step();
        core_set(0, 0, 0, 0, 0);
        step();

        // Core read of 0x40.
        core_set(1, 0, 32'h40, 0, 4'hF);
        smp();
        chk("rd_core_gnt", bus.core_gnt, 1);
        step();
        core_set(0, 0, 0, 0, 0);
        smp();
        chk("rd_core_rvalid", bus.core_rvalid, 1);
        chk("rd_core_rdata", bus.core_rdata, 32'hDEAD_BEEF);
        chk("rd_dbg_rvalid", bus.dbg_rvalid, 0);
        step();

        // Continuous contention: 4 core grants then 1 debug grant, repeating.
        core_set(1, 1, 32'h100, 32'h1111_1111, 4'hF);
        dbg_set(1, 1, 32'h104, 32'h2222_2222, 4'hF);
        for (int i = 0; i < 10; i++) begin
            smp();
            pat[i] = bus.dbg_gnt;
            stl[i] = bus.core_stall;
            step();
        end
        chk("cont_dbg_pattern", pat, 10'b10000_10000);
        chk("cont_stall_pattern", stl, 10'b10000_10000);
        core_set(0, 0, 0, 0, 0);
        dbg_set(0, 0, 0, 0, 0);
        step();

        // Debug partial write to 0x80, then core reads merged word.
        dbg_set(1, 1, 32'h80, 32'h1234_5678, 4'b0011);
        smp();
        chk("dw_dbg_gnt", bus.dbg_gnt, 1);
        chk("dw_mem_mask", bus.mem_mask, 4'b0011);
        step();
        dbg_set(0, 0, 0, 0, 0);
        core_set(1, 0, 32'h80, 0, 4'hF);
        step();
        core_set(0, 0, 0, 0, 0);
        smp();
        chk("dw_core_rvalid", bus.core_rvalid, 1);
        chk("dw_core_rdata", bus.core_rdata, 32'hAAAA_5678);
        step();

        // Back-to-back reads: core then debug.
        core_set(1, 0, 32'h40, 0, 4'hF);
        step();
        core_set(0, 0, 0, 0, 0);
        dbg_set(1, 0, 32'h80, 0, 4'hF);
        smp();
        chk("b2b_core_rvalid", bus.core_rvalid, 1);
        chk("b2b_core_rdata", bus.core_rdata, 32'hDEAD_BEEF);
        chk("b2b_dbg_rvalid0", bus.dbg_rvalid, 0);
        chk("b2b_dbg_gnt", bus.dbg_gnt, 1);
        step();
        dbg_set(0, 0, 0, 0, 0);
        smp();
        chk("b2b_dbg_rvalid", bus.dbg_rvalid, 1);
        chk("b2b_dbg_rdata", bus.dbg_rdata, 32'hAAAA_5678);
        chk("b2b_core_rvalid1", bus.core_rvalid, 0);
        chk("b2b_core_hold", bus.core_rdata, 32'hDEAD_BEEF);
        step();

        // Reset right after a granted read, with the debug port partly starved.
        core_set(1, 0, 32'h40, 0, 4'hF);
        dbg_set(1, 0, 32'h84, 0, 4'hF);
        step();
        step();
        rst = 1'b0;
        core_set(0, 0, 0, 0, 0);
        smp();
        chk("mr_core_rvalid", bus.core_rvalid, 0);
        chk("mr_mem_en", bus.mem_en, 0);
        chk("mr_dbg_gnt", bus.dbg_gnt, 0);
        step();
        rst = 1'b1;
        core_set(1, 0, 32'h44, 0, 4'hF);
        for (int i = 0; i < 5; i++) begin
            smp();
            pat5[i] = bus.dbg_gnt;
            if (i == 0) chk("mr_no_rvalid_after_release", bus.core_rvalid | bus.dbg_rvalid, 0);
            step();
        end
        chk("mr_wait_restart", pat5, 5'b10000);
        core_set(0, 0, 0, 0, 0);
        dbg_set(0, 0, 0, 0, 0);
        step();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the core's load/store stage and a debug/loader port that reads and writes memory while the core runs. It arbitrates per cycle with fixed core priority and a starvation cap for the debug port. It drives the memory's synchronous one-cycle-latency port and routes read data back to the requester that issued the read. It also produces the core stall signal consumed by the pipeline hazard logic.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width; byte mask width is DATA_W/8
MAX_WAIT, 4, cycles the debug port may be refused before it takes priority over the core (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
core_req  in  1  core access request; fields held stable until core_gnt
core_we  in  1  1=write, 0=read
core_addr  in  ADDR_W  byte address
core_wdata  in  DATA_W  write data
core_mask  in  DATA_W/8  byte enables
core_gnt  out  1  core access issued this cycle
core_stall  out  1  core_req & ~core_gnt; freezes the pipeline
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_W  core read data
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mask  in  1/1/ADDR_W/DATA_W/DATA_W/8  debug request, same rules as core
dbg_gnt  out  1  debug access issued this cycle
dbg_rvalid  out  1  debug read data valid
dbg_rdata  out  DATA_W  debug read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_mask  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid cycle after mem_en & ~mem_we

Behaviour:
- Reset (rst=0, async): wait_cnt=0, rd_pend=0, rd_owner=core, all rvalid=0; rdata outputs 0. Outputs derived combinationally from req inputs follow the rules below even during reset, except that no grant is issued while rst=0.
- Grant (combinational, one per cycle): dbg_pri = (wait_cnt==MAX_WAIT). If dbg_pri & dbg_req -> dbg_gnt. Else if core_req -> core_gnt. Else if dbg_req -> dbg_gnt. Never both.
- Memory mux: mem_en = core_gnt|dbg_gnt; mem_we/addr/wdata/mask from the granted requester; all 0 when no grant.
- Starvation counter, width $clog2(MAX_WAIT+1): on dbg_gnt -> 0; else if dbg_req -> +1, saturating at MAX_WAIT; else -> 0 (request withdrawn).
- Read return: on a granted read, rd_pend<=1, rd_owner<=granted port; next cycle the owner's rvalid=1 and rdata=mem_rdata (registered via the owner path; non-owner rvalid=0, rdata holds last value). rd_pend clears unless another read is granted the same cycle (back-to-back reads give one rvalid per cycle).
- Writes produce no rvalid; a write completes on its grant cycle.
- Handshake: request fields are sampled only in the grant cycle; a requester may drop req before grant without side effect.
- Reset mid-read: a pending rvalid is discarded; no rvalid follows reset release.
- Throughput: 1 access/cycle; read latency 1 cycle from grant to rvalid.

Test Plan:
- Reset: rst=0 with core_req=1 -> mem_en=0, core_gnt=0, core_stall=1, both rvalid=0; release -> core_gnt=1 same cycle.
- Core read: mem holds 0xDEADBEEF at 0x40; core read 0x40 -> core_gnt cycle N, core_rvalid=1 and core_rdata=0xDEADBEEF at N+1, dbg_rvalid=0.
- Contention: core_req and dbg_req held continuously, MAX_WAIT=4 -> core granted 4 cycles, dbg granted 5th, pattern repeats 4:1; core_stall=1 only on dbg cycles.
- Debug write then core read: dbg write 0x12345678 mask 4'b0011 to 0x80 (old 0xAAAAAAAA), then core read 0x80 -> core_rdata=0xAAAA5678.
- Back-to-back reads core then dbg on consecutive grants -> core_rvalid cycle N+1, dbg_rvalid cycle N+2, correct data each, no overlap.
- Reset asserted the cycle after a granted read -> no rvalid emitted, wait_cnt=0 after release.
